instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, is the first fetch address after reset.
REQ-002 Parameter MAX_WAIT, default 15, is the number of cycles a request may wait for ImemAck before a fetch error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ImemReq  output  1  fetch request to instruction memory.
REQ-006 ImemAddr  output  32  word-aligned fetch address.
REQ-007 ImemAck  input  1  memory acknowledge; ImemData valid this cycle.
REQ-008 ImemData  input  32  instruction word from memory.
REQ-009 Stall  input  1  downstream (decode/control) not ready to consume.
REQ-010 BranchTaken  input  1  redirect request, meaningful only at a consume edge.
REQ-011 BranchTarget  input  32  redirect address.
REQ-012 Instruction  output  32  held instruction word.
REQ-013 OP  output  6  Instruction[31:26], the opcode presented to the control unit.
REQ-014 InstrValid  output  1  Instruction/OP/PC_out are valid.
REQ-015 PC_out  output  32  address of the held instruction.
REQ-016 PCPlus4  output  32  PC_out + 4, modulo 2^32.
REQ-017 FetchError  output  1  sticky error flag.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, REQ, HOLD and ERROR.
REQ-019 IDLE SHALL last one cycle after reset deassertion and then go to REQ.
REQ-020 In REQ, ImemReq SHALL be 1; ImemAddr = PC; ImemAddr SHALL stay stable until the ack edge.
REQ-021 In REQ with ImemAck=1: capture ImemData into Instruction; PC_out = PC; PC = PC+4 (wraps 32'hFFFF_FFFC -> 0); go to HOLD.
REQ-022 In HOLD: InstrValid=1; ImemReq=0; Instruction, OP and PC_out SHALL be held constant.
REQ-023 Consume edge = HOLD with Stall=0; the next state is REQ.
REQ-024 At a consume edge with BranchTaken=1: PC = BranchTarget, overriding PC+4.
REQ-025 BranchTaken outside a consume edge SHALL be ignored.
REQ-026 ImemAck outside REQ SHALL be ignored.
REQ-027 Minimum cadence: one instruction per 2 cycles (REQ with same-cycle ack, then HOLD with Stall=0).
REQ-028 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-029 When the wait counter reaches MAX_WAIT with no ack, the FSM SHALL go to ERROR.
REQ-030 An ack in the same cycle the wait counter reaches MAX_WAIT SHALL win: the fetch completes normally.
REQ-031 A consume edge with BranchTaken=1 and BranchTarget[1:0]!=0 SHALL go to ERROR without fetching.
REQ-032 In ERROR: FetchError=1; ImemReq=0; InstrValid=0; the FSM stays in ERROR until reset.
REQ-033 InstrValid SHALL be 1 only in HOLD.
REQ-034 OP SHALL always equal Instruction[31:26], including while invalid.
REQ-035 PCPlus4 SHALL be combinational from PC_out.

Reset
REQ-036 reset=0 SHALL immediately, without waiting for clk, force: state=IDLE; PC=RESET_PC; PC_out=RESET_PC; Instruction=0; InstrValid=0; ImemReq=0; FetchError=0; wait counter=0.
REQ-037 Reset asserted mid-REQ or mid-HOLD SHALL abandon the transaction; a late ImemAck SHALL have no effect.

Structure
REQ-038 A shared package SHALL hold the state encodings (2-bit) and the RESET_PC default.
REQ-039 The wait counter SHALL be a sub-module, fetch_wait_counter, with clear, enable and terminal-count output.

Verification
REQ-040 Reset release, ack same cycle as first ImemReq, Stall=0 -> ImemAddr=32'h0040_0000, then 32'h0040_0004 two cycles later; OP matches ImemData[31:26].
REQ-041 ImemData=32'h2008_0005 returned, Stall=1 for 3 cycles -> InstrValid high 4 cycles; OP=6'h08 and PC_out constant; no ImemReq during the stall.
REQ-042 Consume with BranchTaken=1, BranchTarget=32'h0040_0100 -> next ImemAddr=32'h0040_0100.
REQ-043 ImemAck held 0 for 15 cycles -> FetchError=1 and ImemReq=0; ack on cycle 15 -> normal HOLD.
REQ-044 BranchTarget=32'h0040_0102 at consume -> ERROR, FetchError sticky until reset=0.
REQ-045 RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000; reset=0 mid-REQ -> outputs cleared asynchronously.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the instruction fetch unit: FSM encodings, bus widths, reset PC.
package instruction_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 6;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/acknowledge bus between fetch unit and memory.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic            ImemReq;
  logic [XLEN-1:0] ImemAddr;
  logic            ImemAck;
  logic [XLEN-1:0] ImemData;

  modport master (output ImemReq, ImemAddr, input ImemAck, ImemData);
  modport slave  (input ImemReq, ImemAddr, output ImemAck, ImemData);
endinterface

// File: rtl/fetch_wait_counter.sv
// Counts unacknowledged request cycles; tc_c flags the cycle that would reach MAX_WAIT.
module fetch_wait_counter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc_c
);

  localparam int unsigned     CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)       count_d = '0;
    else if (enable) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  // Terminal when this un-acked cycle brings the count up to MAX_WAIT.
  assign tc_c = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch FSM: request, hold for decode, redirect, timeout error.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0]  RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned  MAX_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  instruction_fetch_if.master    imem,
  input  logic                   Stall,
  input  logic                   BranchTaken,
  input  logic [XLEN-1:0]        BranchTarget,
  output logic [XLEN-1:0]        Instruction,
  output logic [OP_W-1:0]        OP,
  output logic                   InstrValid,
  output logic [XLEN-1:0]        PC_out,
  output logic [XLEN-1:0]        PCPlus4,
  output logic                   FetchError
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            imem_req_q, imem_req_d;
  logic            instr_valid_q, instr_valid_d;
  logic            fetch_error_q, fetch_error_d;
  logic            wait_clear, wait_enable, wait_tc_c;

  fetch_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .clear  (wait_clear),
    .enable (wait_enable),
    .tc_c   (wait_tc_c)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_out_d    = pc_out_q;
    instr_d     = instr_q;
    wait_enable = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        wait_enable = !imem.ImemAck;
        if (imem.ImemAck) begin
          instr_d  = imem.ImemData;
          pc_out_d = pc_q;
          pc_d     = pc_inc(pc_q);
          state_d  = ST_HOLD;
        end else if (wait_tc_c) begin
          state_d = ST_ERROR;
        end
      end
      ST_HOLD: begin
        // Consume edge; a misaligned redirect is fatal rather than fetched.
        if (!Stall) begin
          if (BranchTaken && (BranchTarget[1:0] != 2'b00)) begin
            state_d = ST_ERROR;
          end else begin
            if (BranchTaken) pc_d = BranchTarget;
            state_d = ST_REQ;
          end
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
    wait_clear    = (state_d == ST_REQ) && (state_q != ST_REQ);
    imem_req_d    = (state_d == ST_REQ);
    instr_valid_d = (state_d == ST_HOLD);
    fetch_error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      pc_out_q      <= RESET_PC;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_out_q      <= pc_out_d;
      instr_q       <= instr_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      fetch_error_q <= fetch_error_d;
    end
  end

  assign imem.ImemReq  = imem_req_q;
  assign imem.ImemAddr = pc_q;
  assign Instruction   = instr_q;
  assign OP            = instr_q[31:26];
  assign InstrValid    = instr_valid_q;
  assign PC_out        = pc_out_q;
  assign PCPlus4       = pc_inc(pc_out_q);
  assign FetchError    = fetch_error_q;

endmodule
